// File: rtl/fpu_sign_resolve_if.sv
// Handshake and payload bundle between the significand adder, the sign
// finalizer and the result packer.
interface fpu_sign_resolve_if #(
  parameter int unsigned TAG_W = 5
);
  // upstream side
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op_type;
  logic             prod_sign;
  logic             zs;
  logic             mag_z_gt;
  logic             sum_zero;
  logic [2:0]       rm;
  logic             nan_in;
  logic             inf_a;
  logic             inf_z;
  logic [TAG_W-1:0] in_tag;

  // downstream side
  logic             out_valid;
  logic             out_ready;
  logic             out_sign;
  logic             out_nan;
  logic             out_invalid;
  logic             out_illegal;
  logic [TAG_W-1:0] out_tag;

  // producer/consumer view (drives operations, accepts results)
  modport master (
    output in_valid, op_type, prod_sign, zs, mag_z_gt, sum_zero, rm,
           nan_in, inf_a, inf_z, in_tag, out_ready,
    input  in_ready, out_valid, out_sign, out_nan, out_invalid,
           out_illegal, out_tag
  );

  // sign finalizer view
  modport slave (
    input  in_valid, op_type, prod_sign, zs, mag_z_gt, sum_zero, rm,
           nan_in, inf_a, inf_z, in_tag, out_ready,
    output in_ready, out_valid, out_sign, out_nan, out_invalid,
           out_illegal, out_tag
  );
endinterface

// File: rtl/fpu_sign_resolve.sv
// Two-stage sign finalizer for the FPU add/FMA path: resolves the IEEE-754
// result sign (cancellation zero, negated FMA forms, NaN/invalid/illegal).
module fpu_sign_resolve #(
  parameter int unsigned TAG_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  fpu_sign_resolve_if.slave  bus
);

  localparam logic [2:0] OP_SUB    = 3'b001;
  localparam logic [2:0] OP_MUL    = 3'b010;
  localparam logic [2:0] OP_FMS    = 3'b100;
  localparam logic [2:0] OP_FNMADD = 3'b101;
  localparam logic [2:0] OP_FNMSUB = 3'b110;
  localparam logic [2:0] OP_ILL    = 3'b111;
  localparam logic [2:0] RM_RDN    = 3'b010;

  // stage 1 state
  logic             s1_valid;
  logic [2:0]       s1_op;
  logic             s1_prod_sign;
  logic             s1_z_eff;
  logic             s1_eff_sub;
  logic             s1_neg;
  logic             s1_mag_z_gt;
  logic             s1_sum_zero;
  logic [2:0]       s1_rm;
  logic             s1_nan;
  logic             s1_inf_a;
  logic             s1_inf_z;
  logic [TAG_W-1:0] s1_tag;

  // stage 2 (output) state
  logic             s2_valid;
  logic             s2_sign;
  logic             s2_nan;
  logic             s2_invalid;
  logic             s2_illegal;
  logic [TAG_W-1:0] s2_tag;

  logic             s1_adv_c;
  logic             in_ready_c;
  logic             accept_c;
  logic             z_eff_c;
  logic             eff_sub_c;
  logic             neg_c;
  logic             base_sign_c;
  logic             nxt_sign_c;
  logic             nxt_nan_c;
  logic             nxt_invalid_c;
  logic             nxt_illegal_c;

  assign s1_adv_c   = !s2_valid || bus.out_ready;
  assign in_ready_c = !s1_valid || s1_adv_c;
  assign accept_c   = bus.in_valid && in_ready_c;

  // Effective addend sign, effective subtraction and final negation flag.
  always_comb begin
    z_eff_c   = bus.zs;
    eff_sub_c = 1'b0;
    neg_c     = 1'b0;
    if (bus.op_type == OP_SUB || bus.op_type == OP_FMS || bus.op_type == OP_FNMSUB)
      z_eff_c = !bus.zs;
    if (bus.op_type != OP_MUL)
      eff_sub_c = bus.prod_sign ^ z_eff_c;
    if (bus.op_type == OP_FNMADD || bus.op_type == OP_FNMSUB)
      neg_c = 1'b1;
  end

  // Stage 1 valid bit; flush beats a concurrent acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          s1_valid <= 1'b0;
    else if (flush)      s1_valid <= 1'b0;
    else if (in_ready_c) s1_valid <= bus.in_valid;
  end

  // Stage 1 payload, loaded only on acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_op        <= 3'b000;
      s1_prod_sign <= 1'b0;
      s1_z_eff     <= 1'b0;
      s1_eff_sub   <= 1'b0;
      s1_neg       <= 1'b0;
      s1_mag_z_gt  <= 1'b0;
      s1_sum_zero  <= 1'b0;
      s1_rm        <= 3'b000;
      s1_nan       <= 1'b0;
      s1_inf_a     <= 1'b0;
      s1_inf_z     <= 1'b0;
      s1_tag       <= '0;
    end else if (accept_c) begin
      s1_op        <= bus.op_type;
      s1_prod_sign <= bus.prod_sign;
      s1_z_eff     <= z_eff_c;
      s1_eff_sub   <= eff_sub_c;
      s1_neg       <= neg_c;
      s1_mag_z_gt  <= bus.mag_z_gt;
      s1_sum_zero  <= bus.sum_zero;
      s1_rm        <= bus.rm;
      s1_nan       <= bus.nan_in;
      s1_inf_a     <= bus.inf_a;
      s1_inf_z     <= bus.inf_z;
      s1_tag       <= bus.in_tag;
    end
  end

  // Prioritised sign/flag resolution from the stage 1 fields.
  always_comb begin
    base_sign_c   = 1'b0;
    nxt_sign_c    = 1'b0;
    nxt_nan_c     = 1'b0;
    nxt_invalid_c = 1'b0;
    nxt_illegal_c = 1'b0;
    if (s1_op == OP_ILL) begin
      nxt_illegal_c = 1'b1;
    end else if (s1_nan) begin
      nxt_nan_c = 1'b1;
    end else if (s1_inf_a && s1_inf_z && s1_eff_sub) begin
      nxt_nan_c     = 1'b1;
      nxt_invalid_c = 1'b1;
    end else begin
      if (s1_op == OP_MUL || !s1_eff_sub)
        base_sign_c = s1_prod_sign;
      else if (s1_sum_zero)
        base_sign_c = (s1_rm == RM_RDN);
      else
        base_sign_c = s1_mag_z_gt ? s1_z_eff : s1_prod_sign;
      // negation comes after the zero rule: FNMADD cancellation under RNE is -0
      nxt_sign_c = base_sign_c ^ s1_neg;
    end
  end

  // Stage 2 valid bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        s2_valid <= 1'b0;
    else if (flush)    s2_valid <= 1'b0;
    else if (s1_adv_c) s2_valid <= s1_valid;
  end

  // Stage 2 result registers; held while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_sign    <= 1'b0;
      s2_nan     <= 1'b0;
      s2_invalid <= 1'b0;
      s2_illegal <= 1'b0;
      s2_tag     <= '0;
    end else if (s1_adv_c && s1_valid) begin
      s2_sign    <= nxt_sign_c;
      s2_nan     <= nxt_nan_c;
      s2_invalid <= nxt_invalid_c;
      s2_illegal <= nxt_illegal_c;
      s2_tag     <= s1_tag;
    end
  end

  assign bus.in_ready    = in_ready_c;
  assign bus.out_valid   = s2_valid;
  assign bus.out_sign    = s2_sign;
  assign bus.out_nan     = s2_nan;
  assign bus.out_invalid = s2_invalid;
  assign bus.out_illegal = s2_illegal;
  assign bus.out_tag     = s2_tag;

endmodule

// File: tb/tb_fpu_sign_resolve.sv
// Randomised and directed scoreboard bench for fpu_sign_resolve.
module tb_fpu_sign_resolve;

  localparam int unsigned TAG_W = 5;

  typedef struct packed {
    logic [2:0]       op;
    logic             ps;
    logic             zs;
    logic             gt;
    logic             sz;
    logic [2:0]       rm;
    logic             nan;
    logic             ia;
    logic             iz;
    logic [TAG_W-1:0] tag;
  } op_t;

  typedef struct packed {
    logic             sign;
    logic             nan;
    logic             inv;
    logic             ill;
    logic [TAG_W-1:0] tag;
  } res_t;

  logic clk;
  logic rst_n;
  logic flush;

  fpu_sign_resolve_if #(.TAG_W(TAG_W)) bus ();

  fpu_sign_resolve #(.TAG_W(TAG_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_errors = 0;
  res_t exp_q[$];
  bit   hold_pending = 0;
  res_t held;
  int   stall_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: result of (+/-A) + (+/-Z) in IEEE-754 terms, optionally negated.
  function automatic res_t ref_model(input op_t o);
    res_t r;
    bit   a_s, z_s, is_mul, is_neg, s;
    r = '0;
    r.tag = o.tag;
    if (o.op == 3'd7) begin
      r.ill = 1'b1;
      return r;
    end
    if (o.nan) begin
      r.nan = 1'b1;
      return r;
    end
    a_s    = o.ps;
    z_s    = o.zs ^ (o.op inside {3'd1, 3'd4, 3'd6});
    is_mul = (o.op == 3'd2);
    is_neg = (o.op inside {3'd5, 3'd6});
    if (!is_mul && o.ia && o.iz && (a_s != z_s)) begin
      r.nan = 1'b1;
      r.inv = 1'b1;
      return r;
    end
    if (is_mul)              s = a_s;
    else if (a_s == z_s)     s = a_s;            // like signs: magnitudes add
    else if (o.sz)           s = (o.rm == 3'd2); // exact cancellation
    else                     s = o.gt ? z_s : a_s; // larger magnitude wins
    r.sign = s ^ is_neg;
    return r;
  endfunction

  function automatic res_t observed();
    res_t r;
    r.sign = bus.out_sign;
    r.nan  = bus.out_nan;
    r.inv  = bus.out_invalid;
    r.ill  = bus.out_illegal;
    r.tag  = bus.out_tag;
    return r;
  endfunction

  // One clock cycle: drive at negedge, check at negedge+1, model the next posedge.
  task automatic step(input bit v, input op_t o, input bit ordy, input bit fl, output bit accepted);
    res_t obs, e;
    @(negedge clk);
    bus.in_valid  = v;
    bus.op_type   = o.op;
    bus.prod_sign = o.ps;
    bus.zs        = o.zs;
    bus.mag_z_gt  = o.gt;
    bus.sum_zero  = o.sz;
    bus.rm        = o.rm;
    bus.nan_in    = o.nan;
    bus.inf_a     = o.ia;
    bus.inf_z     = o.iz;
    bus.in_tag    = o.tag;
    bus.out_ready = ordy;
    flush         = fl;
    #1;
    obs = observed();
    check("in_ready", 32'(bus.in_ready), 32'((exp_q.size() < 2) || ordy));
    if (exp_q.size() == 0) check("out_valid_empty", 32'(bus.out_valid), 32'd0);
    if (exp_q.size() == 2) check("out_valid_full", 32'(bus.out_valid), 32'd1);
    if (hold_pending) begin
      check("hold_valid", 32'(bus.out_valid), 32'd1);
      check("hold_data", 32'(obs), 32'(held));
    end
    if (bus.out_valid && ordy) begin
      stall_cnt = 0;
      if (exp_q.size() == 0) begin
        check("unexpected_out", 32'(bus.out_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("out_sign", 32'(obs.sign), 32'(e.sign));
        check("out_nan", 32'(obs.nan), 32'(e.nan));
        check("out_invalid", 32'(obs.inv), 32'(e.inv));
        check("out_illegal", 32'(obs.ill), 32'(e.ill));
        check("out_tag", 32'(obs.tag), 32'(e.tag));
      end
    end else if (exp_q.size() != 0) begin
      stall_cnt++;
      if (stall_cnt > 60) begin
        check("retire_timeout", 32'(stall_cnt), 32'd60);
        stall_cnt = 0;
      end
    end
    hold_pending = bus.out_valid && !ordy && !fl;
    held         = obs;
    accepted     = v && bus.in_ready && !fl;
    if (accepted) exp_q.push_back(ref_model(o));
    if (fl) begin
      exp_q.delete();
      stall_cnt = 0;
    end
  endtask

  function automatic op_t mk(input logic [2:0] op, input logic ps, input logic zs,
                             input logic gt, input logic sz, input logic [2:0] rm,
                             input logic [TAG_W-1:0] tag);
    op_t o;
    o     = '0;
    o.op  = op;
    o.ps  = ps;
    o.zs  = zs;
    o.gt  = gt;
    o.sz  = sz;
    o.rm  = rm;
    o.tag = tag;
    return o;
  endfunction

  function automatic op_t rnd_op();
    op_t o;
    o.op  = 3'($urandom_range(0, 7));
    o.ps  = 1'($urandom);
    o.zs  = 1'($urandom);
    o.gt  = 1'($urandom);
    o.sz  = 1'($urandom);
    o.rm  = 3'($urandom);
    o.nan = ($urandom_range(0, 7) == 0);
    o.ia  = ($urandom_range(0, 3) == 0);
    o.iz  = ($urandom_range(0, 3) == 0);
    o.tag = TAG_W'($urandom);
    return o;
  endfunction

  op_t idle;
  bit  acc;
  int  cyc;
  op_t o;

  initial begin
    idle  = '0;
    rst_n = 1'b0;
    flush = 1'b0;
    bus.in_valid = 1'b0; bus.op_type = 3'd0; bus.prod_sign = 1'b0; bus.zs = 1'b0;
    bus.mag_z_gt = 1'b0; bus.sum_zero = 1'b0; bus.rm = 3'd0; bus.nan_in = 1'b0;
    bus.inf_a = 1'b0; bus.inf_z = 1'b0; bus.in_tag = '0; bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_flags", 32'({bus.out_sign, bus.out_nan, bus.out_invalid, bus.out_illegal}), 32'd0);
    check("rst_tag", 32'(bus.out_tag), 32'd0);

    // FMA cancellation under RNE then RDN; FNMADD; SUB swap; specials
    step(1, mk(3'd3, 0, 1, 0, 1, 3'd0, 5'd1), 1, 0, acc);
    step(1, mk(3'd3, 0, 1, 0, 1, 3'd2, 5'd2), 1, 0, acc);
    step(1, mk(3'd5, 0, 1, 0, 1, 3'd0, 5'd3), 1, 0, acc);
    step(1, mk(3'd5, 1, 1, 0, 0, 3'd0, 5'd4), 1, 0, acc);
    step(1, mk(3'd1, 0, 0, 1, 0, 3'd0, 5'd5), 1, 0, acc);
    step(1, mk(3'd1, 0, 0, 0, 0, 3'd0, 5'd6), 1, 0, acc);
    o = mk(3'd4, 0, 0, 0, 0, 3'd0, 5'd7);
    o.ia = 1'b1;
    o.iz = 1'b1;
    step(1, o, 1, 0, acc);
    step(1, mk(3'd7, 1, 1, 1, 1, 3'd2, 5'd8), 1, 0, acc);
    step(1, mk(3'd2, 1, 0, 1, 1, 3'd2, 5'd9), 1, 0, acc);
    repeat (3) step(0, idle, 1, 0, acc);

    // backpressure: tags 1..6, out_ready toggles every 2 cycles
    cyc = 0;
    for (int t = 1; t <= 6; t++) begin
      acc = 0;
      while (!acc && cyc < 200) begin
        step(1, mk(3'd0, 1'(t), 0, 0, 0, 3'd0, TAG_W'(t)), ((cyc / 2) % 2) == 1, 0, acc);
        cyc++;
      end
    end
    while (exp_q.size() != 0 && cyc < 300) begin
      step(0, idle, ((cyc / 2) % 2) == 1, 0, acc);
      cyc++;
    end
    check("bp_drained", 32'(exp_q.size()), 32'd0);

    // flush with two in flight plus a concurrent input
    step(1, mk(3'd0, 0, 0, 0, 0, 3'd0, 5'd20), 0, 0, acc);
    step(1, mk(3'd0, 1, 1, 0, 0, 3'd0, 5'd21), 0, 0, acc);
    step(1, mk(3'd0, 1, 1, 0, 0, 3'd0, 5'd22), 0, 1, acc);
    step(0, idle, 1, 0, acc);
    check("flush_out_valid", 32'(bus.out_valid), 32'd0);
    repeat (3) step(0, idle, 1, 0, acc);

    // async reset mid-cycle with flagged ops in flight
    o = mk(3'd0, 0, 0, 0, 0, 3'd0, 5'd25);
    o.nan = 1'b1;
    step(1, o, 0, 0, acc);
    step(1, mk(3'd7, 0, 0, 0, 0, 3'd0, 5'd26), 0, 0, acc);
    step(0, idle, 0, 0, acc);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(bus.out_valid), 32'd0);
    check("arst_flags", 32'({bus.out_sign, bus.out_nan, bus.out_invalid, bus.out_illegal}), 32'd0);
    check("arst_tag", 32'(bus.out_tag), 32'd0);
    check("arst_in_ready", 32'(bus.in_ready), 32'd1);
    exp_q.delete();
    hold_pending = 0;
    stall_cnt = 0;
    #1;
    rst_n = 1'b1;

    // randomised traffic
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 3) != 0, rnd_op(), $urandom_range(0, 9) < 7,
           $urandom_range(0, 31) == 0, acc);
    end
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 20) begin
      step(0, idle, 1, 0, acc);
      cyc++;
    end
    check("final_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fpu_sign_resolve.md
# fpu_sign_resolve

Two-stage pipelined sign finalizer for the FPU add/FMA datapath. It consumes the preliminary product/addend sign produced by `fpu_sign_logic`, together with the adder's magnitude-compare and zero outputs, the rounding mode and special-value flags. It emits the IEEE-754 final result sign, including:
- exact-cancellation zero sign;
- FNMADD/FNMSUB negation;
- canonical NaN signalling.

It sits between the significand adder and the result packer, with valid/ready flow control on both sides.

## Interface
- `TAG_W`, default 5: width of the opaque tag (destination register) carried with each operation.
- `clk`, input, 1: clock; all state updates on the rising edge.
- `rst_n`, input, 1: asynchronous active-low reset.
- `flush`, input, 1: synchronous pipeline flush.
- `in_valid`, input, 1: upstream operation valid.
- `in_ready`, output, 1: block can accept this cycle.
- `op_type`, input, 3: operation code.
  - `000` ADD, `001` SUB, `010` MUL, `011` FMA.
  - `100` FMS, `101` FNMADD, `110` FNMSUB, `111` illegal.
- `prod_sign`, input, 1: sign of operand A (`xs^ys` for multiply ops, `xs` for ADD/SUB).
- `zs`, input, 1: raw sign of addend Z.
- `mag_z_gt`, input, 1: |Z| > |A| (adder swapped operands).
- `sum_zero`, input, 1: adder result is exactly zero.
- `rm`, input, 3: RISC-V rounding mode (`010` = RDN).
- `nan_in`, input, 1: any operand is NaN.
- `inf_a`, input, 1: A is infinite.
- `inf_z`, input, 1: Z is infinite.
- `in_tag`, input, `TAG_W`: passthrough tag.
- `out_valid`, output, 1: result valid.
- `out_ready`, input, 1: downstream accepts.
- `out_sign`, output, 1: final result sign.
- `out_nan`, output, 1: result is canonical NaN.
- `out_invalid`, output, 1: NV exception (inf − inf).
- `out_illegal`, output, 1: `op_type` was `111`.
- `out_tag`, output, `TAG_W`: tag of the result.

## Operation

**Stage 1** registers the following on acceptance:
- `z_eff = zs ^ (op ∈ {SUB, FMS, FNMSUB})`.
- `eff_sub = prod_sign ^ z_eff`, forced to 0 for MUL.
- `neg = (op ∈ {FNMADD, FNMSUB})`.
- Raw inputs and tag.

**Stage 2** computes the sign in priority order:
1. **Illegal op** (`111`): `out_sign=0`, `out_illegal=1`, all other flags 0.
2. **NaN input**: `nan_in`=1 → `out_nan=1`, `out_sign=0`.
3. **Invalid inf − inf**: `inf_a & inf_z & eff_sub` (non-MUL) → `out_nan=1`, `out_invalid=1`, `out_sign=0`.
4. **MUL**: sign = `prod_sign`.
5. **Exact zero** (`sum_zero`, non-MUL):
   - `eff_sub=0` → sign = `prod_sign`.
   - Otherwise sign = (`rm==RDN`) ? 1 : 0.
6. **Nonzero**:
   - `eff_sub=0` → sign = `prod_sign`.
   - Otherwise sign = `mag_z_gt ? z_eff : prod_sign`.

Final `out_sign = sign ^ neg` for cases 4–6. The negation applies after the zero rule, so FNMADD cancellation under RNE gives −0. NaN and illegal results are never negated.

**Flow control:**
- `s1_adv = !s2_valid | out_ready`.
- `in_ready = !s1_valid | s1_adv`; combinational, no dependency on `in_valid`.
- Data registers load only when their stage advances. Stalled outputs hold stable.

**Flush:** clears `s1_valid` and `s2_valid` on the next edge. Flush wins over a simultaneous acceptance, and the accepted input is dropped.

## Timing
- Latency 2: an op accepted at edge k appears with `out_valid=1` after edge k+1.
- Throughput: 1 op/cycle when `out_ready=1`.
- **Reset** (`rst_n`=0, asynchronous):
  - Valid bits cleared: `s1_valid`, `s2_valid`, hence `out_valid=0`.
  - Outputs cleared: `out_sign`, `out_nan`, `out_invalid`, `out_illegal` = 0; `out_tag` = 0.
  - Deasserting reset mid-stream loses in-flight ops; there is no replay.
- **Full** (both stages valid, `out_ready=0`): `in_ready=0`; nothing changes.
- **Simultaneous** `out_ready=1` with a full pipe: the s2 result retires, s1 moves to s2, and a new input is accepted in the same edge.
- `out_valid` must not drop while `out_ready=0`, except on flush or reset.
- No combinational path from `in_*` data to `out_*`.

## Test plan
- **FMA exact cancellation:**
  - Stimulus: FMA, `prod_sign=0`, `zs=1`, `sum_zero=1`, `rm=000`, back-to-back with the same op at `rm=010`.
  - Response: `out_sign` 0 then 1, on consecutive cycles starting 2 cycles after the first accept.
- **FNMADD negation:**
  - Cancellation with `prod_sign=0`, `zs=1`, `rm=000` → `out_sign=1`.
  - Nonzero with `prod_sign=1`, `zs=1` → `out_sign=0`.
- **Sub swap:**
  - SUB, `prod_sign=0`, `zs=0`, `mag_z_gt=1` → `out_sign=1`.
  - Same with `mag_z_gt=0` → `out_sign=0`.
- **Specials:**
  - FMS with `inf_a=inf_z=1`, `prod_sign=0`, `zs=0` → `out_nan=1`, `out_invalid=1`, `out_sign=0`.
  - `op_type=111` → `out_illegal=1`, `out_sign=0`.
- **Backpressure:**
  - Stimulus: stream tags 1..6 with `out_ready` toggled 0/1 every 2 cycles.
  - Response: tags emerge in order 1..6, no loss or duplication; `in_ready=0` whenever both stages are full and `out_ready=0`.
- **Reset/flush:**
  - Flush with 2 ops in flight plus a concurrent `in_valid` → `out_valid=0` the next cycle; the concurrent op is never output.
  - Async `rst_n` pulse mid-cycle → `out_valid=0` and all flags 0 immediately.
